vote_key_debounce: RTL
======================

# vote_key_debounce

Front-end stage of the three-voter decision path: takes the raw, bouncing, active-low push-buttons of voters A, B, C plus a clear key. Synchronizes and debounces each key. Presents clean active-high vote levels and single-cycle press pulses to the downstream majority-vote logic. Optionally latches votes, so each voter toggles a vote by pressing a key instead of holding it.

## Interface
Parameters:
- CNT_MAX, 1_000_000, stable-sample count required to accept a new key level (20 ms at 50 MHz).
- CNT_W, 20, counter width; must satisfy 2^CNT_W > CNT_MAX.

Ports:
- CLK_50M  in  1  system clock, 50 MHz, sole clock domain.
- RST  in  1  reset, asynchronous assert, active-high.
- KEY_IN  in  4  raw keys, active-low, asynchronous to CLK_50M. Bit 0 = A, bit 1 = B, bit 2 = C, bit 3 = CLR.
- VOTE  out  3  vote bits to the majority stage. Bit 0 = A, bit 1 = B, bit 2 = C; 1 = yes.
- PRESS  out  4  one-cycle pulse per key on an accepted release-to-press transition.
- KEY_LVL  out  4  debounced key levels, active-high (1 = pressed).

## Operation
- Per channel, in order:
  - 2-FF synchronizer, reset to 1 (released).
  - Debounce counter.
  - Stable-state register.
- Counter behaviour:
  - Synchronized sample equals the stable state: counter resets to 0.
  - Sample differs: counter increments.
  - Counter at CNT_MAX-1 while the sample still differs: stable state takes the sample value and the counter returns to 0.
- A glitch shorter than CNT_MAX consecutive differing samples is fully rejected. Any single matching sample restarts the count.
- KEY_LVL[i] = inverted stable state.
- PRESS[i] = 1 for exactly the cycle in which KEY_LVL[i] first reads 1. Release produces no pulse.
- VOTE without the latch feature: VOTE = KEY_LVL[2:0]. The CLR channel is still debounced and reported on KEY_LVL[3] and PRESS[3].
- Channels are independent. Simultaneous acceptance on several channels yields simultaneous pulses.

## Timing
- Reset values:
  - VOTE = 0, PRESS = 0, KEY_LVL = 0.
  - Counters = 0; synchronizers and stable states = released.
- Latency from a clean KEY_IN edge to the KEY_LVL/PRESS change is 2 + CNT_MAX cycles (2 synchronizer + CNT_MAX count).
- KEY_LVL, PRESS and VOTE are all registered and update on the same CLK_50M edge. There is no combinational path from KEY_IN.
- PRESS pulse width is always 1 cycle; minimum spacing between pulses on one channel is 2·CNT_MAX cycles.
- Counter never exceeds CNT_MAX-1; there is no wrap-around.
- RST asserted mid-count discards all partial counts and latched votes immediately. After deassertion all keys are treated as released; a key already held is accepted CNT_MAX+2 cycles later, with a PRESS pulse.

## Configuration
- VOTE_LATCH_EN defined:
  - VOTE[i] toggles on PRESS[i].
  - PRESS[3] (CLR) clears VOTE to 000.
  - CLR and a voter press in the same cycle: clear wins, VOTE = 000.
  - Holding a key does not re-toggle.
- VOTE_LATCH_EN undefined: VOTE follows KEY_LVL[2:0] directly; the latch registers and clear logic are not built.

## Structure
- Package vote_pkg:
  - N_KEYS = 4, N_VOTERS = 3, CLR_IDX = 3.
  - Key index constants A_IDX/B_IDX/C_IDX.
  - DEB_CNT_MAX_DEFAULT = 1_000_000.
- Sub-module key_debounce_ch: one channel (synchronizer, counter, stable state, press pulse), parameterized by CNT_MAX/CNT_W, instantiated N_KEYS times.
- Top level holds only the optional vote latch and output mapping.

## Test plan
All scenarios use CNT_MAX = 8 and CNT_W = 4.
- Reset: RST high with KEY_IN = 0000 (all pressed) → VOTE = 000, PRESS = 0000, KEY_LVL = 0000; after release of RST, KEY_LVL = 1111 at cycle 10 with PRESS = 1111 for one cycle.
- Bounce rejection: KEY_IN[0] low for 5 cycles, high 1, low 5 → no change; then held low → KEY_LVL[0] = 1 exactly 10 cycles after the final falling edge, PRESS[0] one cycle.
- Follow mode (macro undefined): A and C held, B released → VOTE = 101; release A → VOTE = 100 after 10 cycles, no PRESS pulse on release.
- Latch mode (macro defined): press/release A twice, B once → VOTE = 010; press CLR → VOTE = 000 in the PRESS[3] cycle.
- Latch mode, simultaneous events: B and CLR edges aligned → PRESS = 1010 in the same cycle, VOTE = 000.
- Reset mid-operation: assert RST at count 5 with VOTE = 111 (latch mode) → all outputs 0 immediately, no PRESS pulse during reset.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared constants for the three-voter key front end.
// Key indices, channel counts and the default debounce length.
package vote_pkg;
  localparam int N_KEYS = 4;
  localparam int N_VOTERS = 3;
  localparam int A_IDX = 0;
  localparam int B_IDX = 1;
  localparam int C_IDX = 2;
  localparam int CLR_IDX = 3;
  localparam int DEB_CNT_MAX_DEFAULT = 1_000_000;
endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce counter,
// stable-state register and a one-cycle press pulse.
module key_debounce_ch
  import vote_pkg::*;
#(
  parameter int CNT_MAX = DEB_CNT_MAX_DEFAULT,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic lvl,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);

  logic [1:0] sync_q;
  logic stable_q;
  logic stable_d;
  logic press_q;
  logic press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic differ;
  logic done;

  assign differ = sync_q[1] ^ stable_q;
  assign done = differ && (cnt_q == LAST);

  // Count differing samples; accept after CNT_MAX in a row.
  always_comb begin
    cnt_d = '0;
    stable_d = stable_q;
    press_d = 1'b0;
    unique case (1'b1)
      !differ: cnt_d = '0;
      done: begin
        stable_d = sync_q[1];
        press_d = ~sync_q[1];
      end
      default: cnt_d = cnt_q + CNT_W'(1);
    endcase
  end

  // Synchronizer and debounce state; idle level is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      stable_q <= 1'b1;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
    end
  end

  assign lvl = ~stable_q;
  assign press = press_q;

endmodule

// File: rtl/vote_key_debounce.sv
// Debounced voter keys feeding the majority stage.
// Define VOTE_LATCH_EN to make each key toggle a latched vote.
module vote_key_debounce
  import vote_pkg::*;
#(
  parameter int CNT_MAX = DEB_CNT_MAX_DEFAULT,
  parameter int CNT_W = 20
) (
  input  logic CLK_50M,
  input  logic RST,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_VOTERS-1:0] VOTE,
  output logic [N_KEYS-1:0] PRESS,
  output logic [N_KEYS-1:0] KEY_LVL
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX(CNT_MAX),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(CLK_50M),
      .rst(RST),
      .key_n(KEY_IN[i]),
      .lvl(KEY_LVL[i]),
      .press(PRESS[i])
    );
  end

`ifdef VOTE_LATCH_EN
  logic [N_VOTERS-1:0] vote_q;

  // Apply this cycle's pulses so VOTE moves on the PRESS edge.
  always_comb begin
    VOTE = vote_q ^ PRESS[N_VOTERS-1:0];
    if (PRESS[CLR_IDX]) VOTE = '0;
  end

  // Hold the latched votes between pulses.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) vote_q <= '0;
    else vote_q <= VOTE;
  end
`else
  assign VOTE = KEY_LVL[N_VOTERS-1:0];
`endif

endmodule
